// File: rtl/sys_pll_mon_pkg.sv
// Shared types and widths for the system PLL lock monitor.
// Also provides a small constant helper for counter sizing.
package sys_pll_mon_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_mon_state_t;

  localparam int RETRY_CNT_W = 8;
  localparam int LOSS_CNT_W  = 16;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sys_pll_lock_sync.sv
// Two-flop synchronizer with synchronous reset to 0.
// Usable for any asynchronous status input.
module sys_pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/sys_pll_lock_monitor.sv
// PLL lock supervisor: drives PLL reset, qualifies lock, gates sys reset.
// Define SYS_PLL_MON_LOSS_CNT_EN to build the lock-loss counter.
module sys_pll_lock_monitor
  import sys_pll_mon_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELOCK_TIMEOUT     = 65536
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic                   sys_rst,
  output logic                   ready,
  output logic [RETRY_CNT_W-1:0] retry_cnt,
  output logic [LOSS_CNT_W-1:0]  loss_cnt,
  output logic [1:0]             state
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES,
    LOCK_STABLE_CYCLES, RELOCK_TIMEOUT)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RELOCK_TIMEOUT - 1);

  logic lock_s;

  sys_pll_lock_sync u_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (locked),
    .q_o (lock_s)
  );

  pll_mon_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d;
  logic                   pll_rst_q, sys_rst_q, ready_q;
  logic                   retry_inc, loss_inc;

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  // RUN has no timed exit, so the counter idles there.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (state_q != RUN) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    retry_d = retry_q;
    if (retry_inc && (retry_q != '1)) retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == PLL_RST);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

`ifdef SYS_PLL_MON_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  always_ff @(posedge refclk) begin
    if (rst)                          loss_q <= '0;
    else if (loss_inc && loss_q != '1) loss_q <= loss_q + 1'b1;
  end

  assign loss_cnt = loss_q;
`else
  logic unused_loss_inc;
  assign unused_loss_inc = loss_inc;
  assign loss_cnt        = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sys_pll_lock_monitor.sv
// Scoreboard bench for sys_pll_lock_monitor (small timing parameters).
// Expected values are queued per clock edge and checked by a monitor.
module tb_sys_pll_lock_monitor;

  localparam int S_STATE = 0;
  localparam int S_PRST  = 1;
  localparam int S_SRST  = 2;
  localparam int S_RDY   = 3;
  localparam int S_RETRY = 4;
  localparam int S_LOSS  = 5;

`ifdef SYS_PLL_MON_LOSS_CNT_EN
  localparam int LEN = 1;
`else
  localparam int LEN = 0;
`endif

  logic        refclk = 1'b0;
  logic        rst;
  logic        locked;
  logic        pll_rst;
  logic        sys_rst;
  logic        ready;
  logic [7:0]  retry_cnt;
  logic [15:0] loss_cnt;
  logic [1:0]  state;

  sys_pll_lock_monitor #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .RELOCK_TIMEOUT     (32)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int          en;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   ecnt    = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   last_en = 0;

  function automatic logic [15:0] sig_val(int s);
    case (s)
      S_STATE: return {14'd0, state};
      S_PRST:  return {15'd0, pll_rst};
      S_SRST:  return {15'd0, sys_rst};
      S_RDY:   return {15'd0, ready};
      S_RETRY: return {8'd0, retry_cnt};
      default: return loss_cnt;
    endcase
  endfunction

  function automatic string sig_nm(int s);
    case (s)
      S_STATE: return "state";
      S_PRST:  return "pll_rst";
      S_SRST:  return "sys_rst";
      S_RDY:   return "ready";
      S_RETRY: return "retry_cnt";
      default: return "loss_cnt";
    endcase
  endfunction

  task automatic push(int en, int sig, int val);
    exp_t e;
    e.en  = en;
    e.sig = sig;
    e.val = 16'(val);
    sbq.push_back(e);
    if (en > last_en) last_en = en;
  endtask

  task automatic wait_to(int n);
    while (ecnt < n) @(negedge refclk);
  endtask

  // Monitor: samples 2 time units after each active edge.
  initial begin
    logic [15:0] act;
    forever begin
      @(posedge refclk);
      ecnt++;
      #2;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].en == ecnt) begin
          n_chk++;
          act = sig_val(sbq[i].sig);
          if (act !== sbq[i].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d",
              sig_nm(sbq[i].sig), ecnt, act, sbq[i].val);
          end
          sbq.delete(i);
        end
      end
      n_chk++;
      if ((sys_rst !== (state != 2'd3)) || (ready !== ~sys_rst) ||
          (pll_rst && !sys_rst)) begin
        n_fail++;
        $display("FAIL invariant @edge %0d: st=%0d prst=%b srst=%b rdy=%b",
          ecnt, state, pll_rst, sys_rst, ready);
      end
    end
  end

  task automatic push_reset(int en);
    push(en, S_STATE, 0);
    push(en, S_PRST,  1);
    push(en, S_SRST,  1);
    push(en, S_RDY,   0);
    push(en, S_RETRY, 0);
    push(en, S_LOSS,  0);
  endtask

  initial begin
    int r, b, c, d, e, t;
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(negedge refclk);

    // Reset state, then timeout retry with no lock
    push_reset(ecnt + 1);
    @(negedge refclk);
    rst = 1'b0;
    r = ecnt;
    push(r + 3,  S_PRST,  1);
    push(r + 4,  S_PRST,  0);
    push(r + 4,  S_STATE, 1);
    push(r + 35, S_PRST,  0);
    push(r + 35, S_RETRY, 0);
    push(r + 36, S_PRST,  1);
    push(r + 36, S_STATE, 0);
    push(r + 36, S_RETRY, 1);
    push(r + 36, S_SRST,  1);
    push(r + 39, S_PRST,  1);
    push(r + 40, S_PRST,  0);
    push(r + 40, S_STATE, 1);

    // Lock acquire
    wait_to(r + 41);
    b = ecnt;
    locked = 1'b1;
    push(b + 2,  S_STATE, 1);
    push(b + 3,  S_STATE, 2);
    push(b + 10, S_STATE, 2);
    push(b + 10, S_SRST,  1);
    push(b + 11, S_STATE, 3);
    push(b + 11, S_SRST,  0);
    push(b + 11, S_RDY,   1);

    // Lock loss in RUN for 20 cycles, then restore
    wait_to(b + 14);
    b = ecnt;
    locked = 1'b0;
    push(b + 2, S_SRST,  0);
    push(b + 3, S_SRST,  1);
    push(b + 3, S_STATE, 1);
    push(b + 3, S_LOSS,  LEN);
    wait_to(b + 20);
    b = ecnt;
    locked = 1'b1;
    push(b + 10, S_STATE, 2);
    push(b + 11, S_STATE, 3);
    push(b + 11, S_RDY,   1);

    // Short lock blip in WAIT_LOCK, then timeout
    wait_to(b + 14);
    b = ecnt;
    locked = 1'b0;
    push(b + 3,  S_STATE, 1);
    push(b + 3,  S_LOSS,  2 * LEN);
    push(b + 7,  S_STATE, 1);
    push(b + 8,  S_STATE, 2);
    push(b + 12, S_STATE, 2);
    push(b + 12, S_SRST,  1);
    push(b + 13, S_STATE, 1);
    push(b + 44, S_STATE, 1);
    push(b + 44, S_RETRY, 1);
    push(b + 45, S_STATE, 0);
    push(b + 45, S_RETRY, 2);
    wait_to(b + 5);
    locked = 1'b1;
    wait_to(b + 10);
    locked = 1'b0;

    // Reach RUN, then 1-cycle rst
    wait_to(b + 50);
    c = ecnt;
    locked = 1'b1;
    push(c + 11, S_STATE, 3);
    wait_to(c + 13);
    d = ecnt;
    rst = 1'b1;
    push_reset(d + 1);
    wait_to(d + 1);
    rst = 1'b0;
    push(d + 4,  S_PRST,  1);
    push(d + 4,  S_STATE, 0);
    push(d + 5,  S_PRST,  0);
    push(d + 5,  S_STATE, 1);
    push(d + 6,  S_STATE, 2);
    push(d + 13, S_STATE, 2);
    push(d + 14, S_STATE, 3);
    push(d + 14, S_RDY,   1);

    // Retry counter saturation over 300 timeouts
    wait_to(d + 16);
    e = ecnt;
    locked = 1'b0;
    push(e + 3,  S_STATE, 1);
    push(e + 3,  S_LOSS,  LEN);
    push(e + 35, S_RETRY, 1);
    push(e + 35 + 36 * 253, S_RETRY, 254);
    push(e + 35 + 36 * 254, S_RETRY, 255);
    push(e + 35 + 36 * 255, S_RETRY, 255);
    t = e + 35 + 36 * 299;
    push(t, S_RETRY, 255);
    push(t, S_STATE, 0);

    wait_to(last_en + 1);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
        sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
